// File: rtl/lmi_trace_pkg.sv
// lmi_trace_pkg: shared constants for the LMI trace capture block.
// Contents:
//   - record width and TR_DATA field positions
//   - record type codes
//   - make_rec(): packs the fields into one trace record
package lmi_trace_pkg;

    localparam int TR_W = 70;

    // TR_DATA field positions (LSB of each field).
    localparam int TR_TYPE_LSB = 68;
    localparam int TR_BE_LSB   = 64;
    localparam int TR_ADDR_LSB = 32;
    localparam int TR_DATA_LSB = 0;

    localparam logic [1:0] TR_TYPE_I   = 2'b00;
    localparam logic [1:0] TR_TYPE_DRD = 2'b01;
    localparam logic [1:0] TR_TYPE_DWR = 2'b10;
    localparam logic [1:0] TR_TYPE_OVF = 2'b11;

    function automatic logic [TR_W-1:0] make_rec(input logic [1:0]  rtype,
                                                 input logic [3:0]  be,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] data);
        return {rtype, be, addr, data};
    endfunction

endpackage

// File: rtl/lmi_trace_fifo.sv
// lmi_trace_fifo: 2-write / 1-read record FIFO.
// Ports:
//   clk, rst              clock, asynchronous active-high reset (control only)
//   wr0_en / wr0_data     first write, lands at the write pointer
//   wr1_en / wr1_data     second write, lands at write pointer + 1 (only with wr0_en)
//   rd_en                 removes the head entry
//   count                 current occupancy, 0..DEPTH
//   head                  entry at the read pointer (stale when count = 0)
// The caller guarantees writes never exceed the free space seen at the
// start of the cycle, so no overflow protection is done here.
module lmi_trace_fifo
    import lmi_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = TR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [WIDTH-1:0]         wr0_data,
    input  logic                     wr1_en,
    input  logic [WIDTH-1:0]         wr1_data,
    input  logic                     rd_en,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    wptr_nxt1;
    logic [AW-1:0]    rptr;
    logic [1:0]       npush;

    assign wptr_nxt1 = wptr + AW'(1);
    assign npush     = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign head      = mem[rptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wptr]      <= wr0_data;
        if (wr1_en) mem[wptr_nxt1] <= wr1_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(npush);
            rptr  <= rptr + AW'(rd_en);
            count <= count + CW'(npush) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/lmi_trace_capture.sv
// lmi_trace_capture: turns LMI watch samples into trace records, buffers them
// and drains them over a valid/ready handshake; inserts an overflow marker
// carrying the number of records dropped while the FIFO had no room.
// Ports:
//   CLK, RESET_D1_R              clock, asynchronous active-high reset
//   TC_ENABLE, TC_IEN, TC_DEN    capture enable and I/D side filters
//   LW_ISAMPLE_S, LW_IADDR_S_R   instruction fetch sample
//   LW_DSAMPLE_W, LW_DWRITE_W_R,
//   LW_DBYEN_W_R, LW_DADDR_W_R,
//   LW_DATA_W_R                  data access sample
//   TR_READY / TR_VALID / TR_DATA  trace record output handshake
//   TC_DROPS                     cumulative dropped records (saturating)
module lmi_trace_capture
    import lmi_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            CLK,
    input  logic            RESET_D1_R,
    input  logic            TC_ENABLE,
    input  logic            TC_IEN,
    input  logic            TC_DEN,
    input  logic            LW_ISAMPLE_S,
    input  logic [31:0]     LW_IADDR_S_R,
    input  logic            LW_DSAMPLE_W,
    input  logic            LW_DWRITE_W_R,
    input  logic [3:0]      LW_DBYEN_W_R,
    input  logic [31:0]     LW_DADDR_W_R,
    input  logic [31:0]     LW_DATA_W_R,
    input  logic            TR_READY,
    output logic            TR_VALID,
    output logic [TR_W-1:0] TR_DATA,
    output logic [15:0]     TC_DROPS
);

    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    logic [1:0]      limit;
    logic [TR_W-1:0] head;

    logic            pend_flag;
    logic [15:0]     pend_cnt;
    logic [15:0]     drops;

    logic            cand_i, cand_d;
    logic [1:0]      pos_i, pos_d;
    logic            push_ovf, push_i, push_d;
    logic            drop_i, drop_d;
    logic [1:0]      ndrop;

    logic [TR_W-1:0] rec_ovf, rec_i, rec_d;
    logic            wr0_en, wr1_en;
    logic [TR_W-1:0] wr0_data, wr1_data;
    logic            pop;

    assign cand_i = TC_ENABLE & TC_IEN & LW_ISAMPLE_S;
    assign cand_d = TC_ENABLE & TC_DEN & LW_DSAMPLE_W;

    // Space is judged on start-of-cycle occupancy; a same-cycle pop frees nothing.
    assign free  = CW'(DEPTH) - count;
    assign limit = (free >= CW'(2)) ? 2'd2 : free[1:0];

    // Slot index of each candidate in priority order marker > I > D; a
    // candidate is pushed only if its index falls below the slot limit.
    assign pos_i    = {1'b0, pend_flag};
    assign pos_d    = {1'b0, pend_flag} + {1'b0, cand_i};
    assign push_ovf = pend_flag & (limit != 2'd0);
    assign push_i   = cand_i & (limit > pos_i);
    assign push_d   = cand_d & (limit > pos_d);

    assign drop_i = cand_i & ~push_i;
    assign drop_d = cand_d & ~push_d;
    assign ndrop  = {1'b0, drop_i} + {1'b0, drop_d};

    assign rec_ovf = make_rec(TR_TYPE_OVF, 4'h0, 32'h0, {16'h0, pend_cnt});
    assign rec_i   = make_rec(TR_TYPE_I, 4'h0, LW_IADDR_S_R, 32'h0);
    assign rec_d   = make_rec(LW_DWRITE_W_R ? TR_TYPE_DWR : TR_TYPE_DRD,
                              LW_DBYEN_W_R, LW_DADDR_W_R, LW_DATA_W_R);

    // Pack the pushed records onto consecutive write slots, keeping priority order.
    assign wr0_en   = push_ovf | push_i | push_d;
    assign wr1_en   = (push_ovf & (push_i | push_d)) | (push_i & push_d);
    assign wr0_data = push_ovf ? rec_ovf : (push_i ? rec_i : rec_d);
    assign wr1_data = (push_ovf & push_i) ? rec_i : rec_d;

    assign TR_VALID = (count != '0);
    assign pop      = TR_VALID & TR_READY;
    assign TR_DATA  = TR_VALID ? head : '0;
    assign TC_DROPS = drops;

    lmi_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TR_W)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RESET_D1_R),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (pop),
        .count    (count),
        .head     (head)
    );

    // Pushing the marker restarts the pending count with this cycle's drops.
    always_ff @(posedge CLK or posedge RESET_D1_R) begin
        if (RESET_D1_R) begin
            pend_flag <= 1'b0;
            pend_cnt  <= '0;
            drops     <= '0;
        end else begin
            if (push_ovf) begin
                pend_flag <= (ndrop != 2'd0);
                pend_cnt  <= {14'd0, ndrop};
            end else begin
                pend_flag <= pend_flag | (ndrop != 2'd0);
                pend_cnt  <= sat_add16(pend_cnt, ndrop);
            end
            drops <= sat_add16(drops, ndrop);
        end
    end

endmodule

// File: doc/lmi_trace_capture.md
# lmi_trace_capture

Consumer of the local-memory-interface watch sample stream. Each cycle it turns the instruction-side and data-side sample strobes into typed trace records, buffers them in a small FIFO, and drains them to the debug/trace port over a valid/ready handshake. When the FIFO overflows, it inserts an overflow marker that carries the number of dropped records. It sits between the LMI watch logic and the trace packetizer in the core's debug subsystem.

## Interface
- DEPTH, 8: number of FIFO entries; must be a power of 2, minimum 4.
- CLK  in  1  core clock.
- RESET_D1_R  in  1  reset, asynchronous, active-high.
- TC_ENABLE  in  1  capture enable.
- TC_IEN  in  1  enables the instruction-side filter.
- TC_DEN  in  1  enables the data-side filter.
- LW_ISAMPLE_S  in  1  instruction fetch sample strobe.
- LW_IADDR_S_R  in  32  instruction fetch address.
- LW_DSAMPLE_W  in  1  data access sample strobe.
- LW_DWRITE_W_R  in  1  1 = write, 0 = read.
- LW_DBYEN_W_R  in  4  data byte enables.
- LW_DADDR_W_R  in  32  data address.
- LW_DATA_W_R  in  32  data value.
- TR_READY  in  1  downstream accepts the head record.
- TR_VALID  out  1  head record is valid.
- TR_DATA  out  70  record: [69:68] type, [67:64] byte enables, [63:32] address, [31:0] data.
- TC_DROPS  out  16  cumulative dropped records, saturating.

## Operation
- Record types:
  - 00 = I fetch: byte enables 0, data 0.
  - 01 = D read.
  - 10 = D write.
  - 11 = overflow marker: address 0, data[15:0] = pending drop count.
- Candidates in a cycle, in priority order:
  - overflow marker, if an overflow is pending;
  - I record, if TC_ENABLE & TC_IEN & LW_ISAMPLE_S;
  - D record, if TC_ENABLE & TC_DEN & LW_DSAMPLE_W.
- Up to 2 pushes per cycle. free = DEPTH − count, where count is the value at the start of the cycle; a same-cycle pop does not create space.
- Candidates take slots in priority order, limited by min(2, free). Candidates beyond that limit are dropped.
- Drops:
  - Each dropped I/D record increments the pending drop count (16-bit, saturating at 0xFFFF), sets the pending flag, and increments TC_DROPS (saturating).
  - An overflow marker is never dropped. It stays pending until it gets a slot.
  - When the marker is pushed, the pending flag clears and the pending count resets to 0. In the same cycle, the count then takes the number of I/D records dropped that cycle; if that number is >0, the flag is set again.
- TC_ENABLE low:
  - samples are ignored and not counted;
  - the FIFO keeps draining;
  - a pending marker is still pushed when space allows.
- Pop: the head entry is removed when TR_VALID & TR_READY.
- TR_VALID = (count != 0). TR_DATA = head entry when TR_VALID, else 0.
- Counters: count' = count + pushes − pop. Read and write pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous) clears count, pointers, pending flag, pending count and TC_DROPS.
  - TR_VALID = 0, TR_DATA = 0, TC_DROPS = 0 while reset is asserted and after it is released.
  - FIFO storage is not reset.
- Reset asserted mid-operation discards all buffered records immediately.
- Latency: a sample strobe in cycle N produces its record in the FIFO at the edge ending N. TR_VALID rises in N+1 if the FIFO was empty.
- Ordering within one cycle: marker, then I, then D, at consecutive write-pointer slots.
- Handshake:
  - TR_DATA and TR_VALID hold steady while TR_VALID & ~TR_READY.
  - Throughput is one pop per cycle.
- Full (count = DEPTH): every candidate is dropped; the marker stays pending.
- Simultaneous push and pop on a full FIFO: pushes are still limited by start-of-cycle free space, so nothing is pushed that cycle.

## Structure
- Package lmi_trace_pkg holds:
  - record type constants TR_TYPE_I, TR_TYPE_DRD, TR_TYPE_DWR, TR_TYPE_OVF;
  - field position constants for TR_DATA;
  - the record width, 70.
- Sub-module lmi_trace_fifo: 2-write/1-read storage with pointers and count, parameterized by DEPTH and width. The top level holds the candidate selection, the overflow logic and the counters.

## Test plan
- Reset: assert RESET_D1_R mid-cycle with 5 entries buffered -> TR_VALID = 0 and TR_DATA = 0 immediately; TC_DROPS = 0.
- Single fetch: ISAMPLE with addr 0x1FC00000 and TR_READY = 1 -> next cycle TR_VALID = 1, TR_DATA = {00, 0, 0x1FC00000, 0}; popped that cycle; TR_VALID = 0 the following cycle.
- Dual push: I at 0x100 plus D write at 0x200, byte enables F, data 0xDEADBEEF, in the same cycle -> two records in I-then-D order, the second with type 10.
- Overflow:
  - DEPTH = 8, TR_READY = 0, 10 consecutive I samples -> 8 stored, TC_DROPS = 2.
  - Then pop 2 and send 1 I sample -> marker with data 2 followed by the I record; pending flag clear.
- Marker-only space: full FIFO with 1 drop pending; pop 1, then send I and D simultaneously -> marker takes the slot, I and D dropped, pending count = 2, TC_DROPS += 2.
- Enable gating: TC_ENABLE = 0 with samples arriving -> no pushes, TC_DROPS unchanged, existing entries still drain.
